// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared Tnew/Tuse constants, default latencies and scoreboard entry type
package hazard_pkg;

  localparam int T_PC  = 0;
  localparam int T_ALU = 1;
  localparam int T_DM  = 2;

  localparam int FWD_RF = 0;

  localparam int MULT_LAT_D = 5;
  localparam int DIV_LAT_D  = 10;

  localparam int RAW_D = 5;
  localparam int TW_D  = 2;

  typedef struct packed {
    logic [RAW_D-1:0] a3;
    logic [TW_D-1:0]  tnew;
  } entry_t;

endpackage

// File: rtl/md_busy_counter.sv
// rtl/md_busy_counter.sv - multiply/divide busy counter: load on start, count down to zero
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_D,
  parameter int DIV_LAT  = DIV_LAT_D
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A start while busy simply reloads; the md stall keeps that from happening legally.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - Tuse/Tnew scoreboard producing stall, forward selects and md busy
// Optional stall statistics counters enabled by HAZARD_STATS_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int RAW      = 5,
  parameter int TW       = 2,
  parameter int MULT_LAT = MULT_LAT_D,
  parameter int DIV_LAT  = DIV_LAT_D,
  localparam int FW      = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [RAW-1:0] id_rs,
  input  logic [RAW-1:0] id_rt,
  input  logic           id_use_rs,
  input  logic           id_use_rt,
  input  logic [TW-1:0]  id_tuse_rs,
  input  logic [TW-1:0]  id_tuse_rt,
  input  logic [RAW-1:0] id_a3,
  input  logic [TW-1:0]  id_tnew,
  input  logic           id_md_use,
  input  logic           ex_md_start,
  input  logic           ex_md_is_div,
  output logic           stall,
  output logic [FW-1:0]  fwd_rs,
  output logic [FW-1:0]  fwd_rt,
  output logic           md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]    stall_cnt,
  output logic [31:0]    md_stall_cnt
`endif
);

  typedef struct packed {
    logic [RAW-1:0] a3;
    logic [TW-1:0]  tnew;
  } sb_entry_t;

  sb_entry_t sb_q [DEPTH];
  sb_entry_t sb_d [DEPTH];

  logic rs_stall, rt_stall, md_stall;
  logic rs_done, rt_done;

  md_busy_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (ex_md_start),
    .is_div (ex_md_is_div),
    .busy   (md_busy)
  );

  // Scan youngest to oldest: the first match decides forwarding, any match may stall.
  always_comb begin
    rs_stall = 1'b0;
    rt_stall = 1'b0;
    rs_done  = 1'b0;
    rt_done  = 1'b0;
    fwd_rs   = FW'(FWD_RF);
    fwd_rt   = FW'(FWD_RF);
    for (int k = 0; k < DEPTH; k++) begin
      if ((sb_q[k].a3 == id_rs) && (id_rs != '0)) begin
        if (sb_q[k].tnew > id_tuse_rs) rs_stall = 1'b1;
        if (!rs_done) begin
          if (sb_q[k].tnew == '0) fwd_rs = FW'(k + 1);
          rs_done = 1'b1;
        end
      end
      if ((sb_q[k].a3 == id_rt) && (id_rt != '0)) begin
        if (sb_q[k].tnew > id_tuse_rt) rt_stall = 1'b1;
        if (!rt_done) begin
          if (sb_q[k].tnew == '0) fwd_rt = FW'(k + 1);
          rt_done = 1'b1;
        end
      end
    end
    rs_stall = rs_stall & id_use_rs;
    rt_stall = rt_stall & id_use_rt;
  end

  assign md_stall = id_md_use & (md_busy | ex_md_start);
  assign stall    = rs_stall | rt_stall | md_stall;

  always_comb begin
    sb_d[0] = stall ? '0 : {id_a3, id_tnew};
    for (int k = 1; k < DEPTH; k++) begin
      sb_d[k].a3   = sb_q[k-1].a3;
      sb_d[k].tnew = (sb_q[k-1].tnew != '0) ? sb_q[k-1].tnew - TW'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (reset) begin
        sb_q[k] <= '0;
      end else begin
        sb_q[k] <= sb_d[k];
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

  always_comb begin
    stall_cnt_d    = stall_cnt_q + {31'd0, stall};
    md_stall_cnt_d = md_stall_cnt_q + {31'd0, md_stall & ~rs_stall & ~rt_stall};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      md_stall_cnt_q <= md_stall_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs, id_rt, id_a3;
  logic          id_use_rs, id_use_rt;
  logic [1:0]    id_tuse_rs, id_tuse_rt, id_tnew;
  logic          id_md_use, ex_md_start, ex_md_is_div;
  logic          stall;
  logic [FW-1:0] fwd_rs, fwd_rt;
  logic          md_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0]   stall_cnt, md_stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_tuse_rs   (id_tuse_rs),
    .id_tuse_rt   (id_tuse_rt),
    .id_a3        (id_a3),
    .id_tnew      (id_tnew),
    .id_md_use    (id_md_use),
    .ex_md_start  (ex_md_start),
    .ex_md_is_div (ex_md_is_div),
    .stall        (stall),
    .fwd_rs       (fwd_rs),
    .fwd_rt       (fwd_rt),
    .md_busy      (md_busy)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .md_stall_cnt (md_stall_cnt)
`endif
  );

  typedef struct {
    string tag;
    int    stall;
    int    frs;
    int    frt;
    int    busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_tuse_rs = '0; id_tuse_rt = '0; id_a3 = '0; id_tnew = '0;
    id_md_use = 1'b0; ex_md_start = 1'b0; ex_md_is_div = 1'b0;
  endtask

  task automatic rd_rs(input logic [4:0] r, input logic [1:0] tuse);
    id_rs = r; id_use_rs = 1'b1; id_tuse_rs = tuse;
  endtask

  task automatic rd_rt(input logic [4:0] r, input logic [1:0] tuse);
    id_rt = r; id_use_rt = 1'b1; id_tuse_rt = tuse;
  endtask

  task automatic wr(input logic [4:0] a3, input int tnew);
    id_a3 = a3; id_tnew = 2'(tnew);
  endtask

  task automatic expect_out(input string tag, input int s, input int frs, input int frt, input int b);
    exp_t e;
    e.tag = tag; e.stall = s; e.frs = frs; e.frt = frt; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("queue_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, ".stall"},  int'(stall),   e.stall);
      check({e.tag, ".fwd_rs"}, int'(fwd_rs),  e.frs);
      check({e.tag, ".fwd_rt"}, int'(fwd_rt),  e.frt);
      check({e.tag, ".busy"},   int'(md_busy), e.busy);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0); cycle();
    reset = 1'b0;

    // lw $1 then dependent beq: stall twice, then forward from WB
    idle(); wr(5'd1, T_DM);                   expect_out("lw",      0, 0, 0, 0); cycle();
    idle(); rd_rs(5'd1, 0); rd_rt(5'd0, 0);   expect_out("beq_ex",  1, 0, 0, 0); cycle();
    idle(); rd_rs(5'd1, 0); rd_rt(5'd0, 0);   expect_out("beq_mem", 1, 0, 0, 0); cycle();
    idle(); rd_rs(5'd1, 0); rd_rt(5'd0, 0);   expect_out("beq_wb",  0, 3, 0, 0); cycle();

    // addu $2 then readers with Tuse = 1
    idle(); wr(5'd2, T_ALU);                  expect_out("addu2",   0, 0, 0, 0); cycle();
    idle(); rd_rs(5'd2, 1); wr(5'd3, T_ALU);  expect_out("use2_ex", 0, 0, 0, 0); cycle();
    idle(); rd_rs(5'd2, 1); rd_rt(5'd3, 1);   expect_out("use2_mem",0, 2, 0, 0); cycle();
    idle(); rd_rs(5'd2, 0); rd_rt(5'd3, 0);   expect_out("use23",   0, 3, 2, 0); cycle();

    // writes to $0 never match
    idle(); wr(5'd0, T_DM);                   expect_out("wr_r0",   0, 0, 0, 0); cycle();
    idle(); rd_rs(5'd0, 0); rd_rt(5'd0, 0);   expect_out("rd_r0",   0, 0, 0, 0); cycle();

    // $5 in EX and MEM, both ready: youngest wins
    idle(); wr(5'd5, T_ALU);                  expect_out("wr5a",    0, 0, 0, 0); cycle();
    idle(); wr(5'd5, T_PC);                   expect_out("wr5b",    0, 0, 0, 0); cycle();
    idle(); rd_rt(5'd5, 0); rd_rs(5'd5, 1);   expect_out("young",   0, 1, 1, 0); cycle();
    idle(); rd_rs(5'd5, 0);                   expect_out("young2",  0, 2, 0, 0); cycle();

    // divide start with mflo waiting in ID
    idle(); ex_md_start = 1'b1; ex_md_is_div = 1'b1; id_md_use = 1'b1; wr(5'd4, T_ALU);
    expect_out("div_start", 1, 0, 0, 0); cycle();
    for (int i = 1; i <= 10; i++) begin
      idle(); id_md_use = 1'b1; wr(5'd4, T_ALU);
      expect_out($sformatf("div_busy%0d", i), 1, 0, 0, 1); cycle();
    end
    idle(); id_md_use = 1'b1; wr(5'd4, T_ALU); expect_out("div_done", 0, 0, 0, 0); cycle();

    // multiply: 5 busy cycles, md user stalls only while busy
    idle(); ex_md_start = 1'b1;               expect_out("mul_start", 0, 0, 0, 0); cycle();
    for (int i = 1; i <= 5; i++) begin
      idle(); id_md_use = (i == 5);
      expect_out($sformatf("mul_busy%0d", i), (i == 5) ? 1 : 0, 0, 0, 1); cycle();
    end
    idle(); id_md_use = 1'b1;                 expect_out("mul_done", 0, 0, 0, 0); cycle();

    // reset during a divide with lw $1 in MEM
    idle(); ex_md_start = 1'b1; ex_md_is_div = 1'b1; wr(5'd1, T_DM);
    expect_out("rst_div", 0, 0, 0, 0); cycle();
    idle();
`ifdef HAZARD_STATS_EN
    check("stall_cnt", int'(stall_cnt), 14);
    check("md_stall_cnt", int'(md_stall_cnt), 12);
`endif
    expect_out("rst_pre", 0, 0, 0, 1); cycle();
    idle(); reset = 1'b1;                     expect_out("rst_cyc", 0, 0, 0, 1); cycle();
    reset = 1'b0;
    idle(); rd_rs(5'd1, 0);                   expect_out("rst_beq", 0, 0, 0, 0); cycle();
    idle(); id_md_use = 1'b1;                 expect_out("rst_md",  0, 0, 0, 0); cycle();

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
